// File: rtl/ds1302_function.sv
// DS1302 3-wire serial engine: runs one single-byte register read or write per
// func_start request, with CE framing, SCLK generation and IO turnaround.
module ds1302_function #(
  parameter int HALF_CNT     = 25,
  parameter int CE_SETUP_CNT = 200,
  parameter int CE_HOLD_CNT  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] func_start,
  input  logic [7:0] register_addr,
  input  logic [7:0] write_data,
  output logic       func_done,
  output logic [7:0] read_data,
  output logic       rtc_ce,
  output logic       rtc_sclk,
  output logic       rtc_io_out,
  output logic       rtc_io_oe,
  input  logic       rtc_io_in
);

  localparam int CNT_MAX = (CE_SETUP_CNT > HALF_CNT)
                         ? ((CE_SETUP_CNT > CE_HOLD_CNT) ? CE_SETUP_CNT : CE_HOLD_CNT)
                         : ((HALF_CNT > CE_HOLD_CNT) ? HALF_CNT : CE_HOLD_CNT);
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CNT - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CE_SETUP_CNT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CE_HOLD_CNT - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       slot_q, slot_d;
  logic             high_q, high_d;
  logic [15:0]      word_q, word_d;
  logic             is_read_q, is_read_d;
  logic [7:0]       rd_q, rd_d;
  logic             done_q, done_d;
  logic [7:0]       read_data_q, read_data_d;
  logic             ce_q, ce_d;
  logic             sclk_q, sclk_d;
  logic             io_out_q, io_out_d;
  logic             oe_q, oe_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    slot_d      = slot_q;
    high_d      = high_q;
    word_d      = word_q;
    is_read_d   = is_read_q;
    rd_d        = rd_q;
    done_d      = 1'b0;
    read_data_d = read_data_q;
    ce_d        = ce_q;
    sclk_d      = sclk_q;
    io_out_d    = io_out_q;
    oe_d        = oe_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (func_start == 2'b10 || func_start == 2'b01) begin
          word_d    = {write_data, register_addr};
          is_read_d = (func_start == 2'b01);
          state_d   = ST_SETUP;
          ce_d      = 1'b1;
          sclk_d    = 1'b0;
          oe_d      = 1'b1;
          io_out_d  = register_addr[0];
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          slot_d  = 4'd0;
          high_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!high_q) begin
            // Read bits are taken at the end of the low phase, just before SCLK rises.
            high_d = 1'b1;
            sclk_d = 1'b1;
            if (is_read_q && slot_q[3]) rd_d[slot_q[2:0]] = rtc_io_in;
          end else begin
            high_d = 1'b0;
            sclk_d = 1'b0;
            if (slot_q == 4'd15) begin
              state_d  = ST_HOLD;
              oe_d     = 1'b0;
              io_out_d = 1'b0;
            end else begin
              slot_d = slot_q + 4'd1;
              if (is_read_q && slot_d[3]) begin
                oe_d     = 1'b0;
                io_out_d = 1'b0;
              end else begin
                io_out_d = word_q[slot_d];
              end
            end
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
          ce_d    = 1'b0;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (is_read_q) read_data_d = rd_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      slot_q      <= 4'd0;
      high_q      <= 1'b0;
      word_q      <= 16'h0000;
      is_read_q   <= 1'b0;
      rd_q        <= 8'h00;
      done_q      <= 1'b0;
      read_data_q <= 8'h00;
      ce_q        <= 1'b0;
      sclk_q      <= 1'b0;
      io_out_q    <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      high_q      <= high_d;
      word_q      <= word_d;
      is_read_q   <= is_read_d;
      rd_q        <= rd_d;
      done_q      <= done_d;
      read_data_q <= read_data_d;
      ce_q        <= ce_d;
      sclk_q      <= sclk_d;
      io_out_q    <= io_out_d;
      oe_q        <= oe_d;
    end
  end

  assign func_done  = done_q;
  assign read_data  = read_data_q;
  assign rtc_ce     = ce_q;
  assign rtc_sclk   = sclk_q;
  assign rtc_io_out = io_out_q;
  assign rtc_io_oe  = oe_q;

endmodule
